push_packet: RTL and testbench

//   Serialises NUM_CH speed samples into a byte stream of DATA_SIZE-bit words for the downstream
//   TX FIFO/UART path. On a done strobe it snapshots all channels and writes them word by word,
//   low word first, with back-pressure from the FIFO and a programmable inter-word gap.
//   It supersedes the fixed 2-word, single-channel pusher.

---
 rtl/push_packet.sv | 189 ++++++++++++++++++
 tb/tb_push_packet.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/push_packet.sv
// push_packet: snapshots NUM_CH speed samples on done and streams them out as DATA_SIZE-bit
// words, low word first, honouring downstream full and a GAP_CYCLES inter-word gap.
// Define PUSH_PACKET_FRAME_EN to wrap the payload with a HEADER word and an XOR checksum word.
module push_packet #(
  parameter int                       WIDTH_SPEED = 14,
  parameter int                       DATA_SIZE   = 8,
  parameter int                       NUM_CH      = 2,
  parameter int                       GAP_CYCLES  = 1,
  parameter logic [DATA_SIZE-1:0]     HEADER      = 8'hA5
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          done,
  input  logic [NUM_CH*WIDTH_SPEED-1:0] speed,
  input  logic                          full,
  output logic                          write,
  output logic [DATA_SIZE-1:0]          data,
  output logic                          busy,
  output logic                          overrun
);

  localparam int BPC = (WIDTH_SPEED + DATA_SIZE - 1) / DATA_SIZE;
  localparam int P   = NUM_CH * BPC;
`ifdef PUSH_PACKET_FRAME_EN
  localparam bit FRAME = 1'b1;
`else
  localparam bit FRAME = 1'b0;
`endif
  localparam int TOT      = FRAME ? P + 2 : P;
  localparam int IW       = $clog2(TOT + 1);
  localparam int GW       = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_write;
  logic [DATA_SIZE-1:0]     r_data;
  logic                     r_busy;
  logic                     r_overrun;
  logic [IW-1:0]            r_idx;
  logic [GW-1:0]            r_gap;
  logic [DATA_SIZE-1:0]     r_csum;
  logic [DATA_SIZE-1:0]     r_snap     [P];
  logic [DATA_SIZE-1:0]     w_snap_nxt [P];
  logic [BPC*DATA_SIZE-1:0] w_pad;
  logic [IW-1:0]            w_pidx;
  logic [DATA_SIZE-1:0]     w_payload;
  logic [DATA_SIZE-1:0]     w_word;
  logic                     w_last;
  logic                     w_is_payload;
  logic                     w_fire;

  function automatic logic [DATA_SIZE-1:0] f_csum_acc(input logic [DATA_SIZE-1:0] acc,
                                                      input logic [DATA_SIZE-1:0] w);
    return acc ^ w;
  endfunction

  // Split every channel into zero-padded words, ready to be captured
  always_comb begin
    w_pad = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_pad = '0;
      w_pad[WIDTH_SPEED-1:0] = speed[c*WIDTH_SPEED +: WIDTH_SPEED];
      for (int b = 0; b < BPC; b++) begin
        w_snap_nxt[c*BPC+b] = w_pad[b*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  // Select the word at the current index: header, payload or checksum
  always_comb begin
    w_last = (r_idx == IW'(TOT - 1));
    w_pidx = FRAME ? (r_idx - IW'(1)) : r_idx;
    w_payload = r_snap[0];
    for (int k = 0; k < P; k++) begin
      w_payload = (w_pidx == IW'(k)) ? r_snap[k] : w_payload;
    end
    w_is_payload = !(FRAME && ((r_idx == '0) || w_last));
    if (FRAME && (r_idx == '0)) begin
      w_word = HEADER;
    end else if (FRAME && w_last) begin
      w_word = r_csum;
    end else begin
      w_word = w_payload;
    end
  end

  // Next state; LOAD already offers word 0 so the first write lands two cycles after done
  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    case (r_state)
      IDLE: begin
        if (done) begin
          w_state_nxt = LOAD;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LOAD, SEND: begin
        if (!full) begin
          w_fire = 1'b1;
          if (w_last) begin
            w_state_nxt = IDLE;
          end else if (GAP_CYCLES > 0) begin
            w_state_nxt = GAP;
          end else begin
            w_state_nxt = SEND;
          end
        end else begin
          w_state_nxt = SEND;
        end
      end
      GAP: begin
        if (r_gap == '0) begin
          w_state_nxt = SEND;
        end else begin
          w_state_nxt = GAP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register and status/strobe outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_write   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_write   <= w_fire;
      r_busy    <= (r_state != IDLE) || (w_state_nxt != IDLE);
      r_overrun <= done && (r_state != IDLE);
    end
  end

  // Output word, word index and running checksum
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
      r_idx  <= '0;
      r_csum <= '0;
    end else if ((r_state == IDLE) && done) begin
      r_idx  <= '0;
      r_csum <= '0;
    end else if (w_fire) begin
      r_data <= w_word;
      r_idx  <= r_idx + IW'(1);
      if (w_is_payload) begin
        r_csum <= f_csum_acc(r_csum, w_word);
      end
    end
  end

  // Channel snapshot, taken only when a request is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < P; k++) begin
        r_snap[k] <= '0;
      end
    end else if ((r_state == IDLE) && done) begin
      for (int k = 0; k < P; k++) begin
        r_snap[k] <= w_snap_nxt[k];
      end
    end
  end

  // Inter-word gap counter; the GAP state overlaps the cycle the write is visible
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gap <= '0;
    end else if (w_fire && (w_state_nxt == GAP)) begin
      r_gap <= GW'(GAP_LOAD);
    end else if ((r_state == GAP) && (r_gap != '0)) begin
      r_gap <= r_gap - GW'(1);
    end
  end

  assign write   = r_write;
  assign data    = r_data;
  assign busy    = r_busy;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_push_packet.sv
// Scoreboard bench for push_packet: expected words and write cycles are queued when done is
// pulsed and compared as writes appear. A second instance covers GAP_CYCLES=0, WIDTH_SPEED=10.
module tb_push_packet;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        done = 1'b0;
  logic        full = 1'b0;
  logic [27:0] speed = 28'h0;
  logic        write, busy, overrun;
  logic [7:0]  data;

  logic        done6 = 1'b0;
  logic        full6 = 1'b0;
  logic [19:0] speed6 = 20'h0;
  logic        write6, busy6, overrun6;
  logic [7:0]  data6;

  push_packet dut (
    .clk(clk), .reset_n(reset_n), .done(done), .speed(speed), .full(full),
    .write(write), .data(data), .busy(busy), .overrun(overrun)
  );

  push_packet #(.WIDTH_SPEED(10), .GAP_CYCLES(0)) dut6 (
    .clk(clk), .reset_n(reset_n), .done(done6), .speed(speed6), .full(full6),
    .write(write6), .data(data6), .busy(busy6), .overrun(overrun6)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;
  exp_t q0[$];
  exp_t q6[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick(1);
    done = 1'b0;
  endtask

  // Build the expected packet from two channel values and queue up to maxw words
  task automatic push_pkt(input int which, input logic [15:0] c0, input logic [15:0] c1,
                          input int ws, input int first, input int step, input int maxw,
                          output int nw, output logic [7:0] last);
    logic [7:0]  w[$];
    logic [7:0]  cs;
    logic [7:0]  byt;
    logic [15:0] v;
    exp_t        e;
    int          bpc;
    bpc = (ws + 7) / 8;
    cs  = 8'h00;
    for (int ch = 0; ch < 2; ch++) begin
      v = (ch == 0) ? c0 : c1;
      for (int b = 0; b < bpc; b++) begin
        byt = v[8*b +: 8];
        w.push_back(byt);
        cs = cs ^ byt;
      end
    end
`ifdef PUSH_PACKET_FRAME_EN
    w.push_front(8'hA5);
    w.push_back(cs);
`endif
    nw   = w.size();
    last = w[nw-1];
    for (int i = 0; i < nw && i < maxw; i++) begin
      e.d = w[i];
      e.c = first + i * step;
      if (which == 6) q6.push_back(e);
      else            q0.push_back(e);
    end
  endtask

  // Scoreboard for the default instance
  always @(negedge clk) begin
    exp_t e;
    if (write) begin
      if (q0.size() == 0) begin
        check_eq("unexpected_write", 32'(write), 32'd0);
      end else begin
        e = q0.pop_front();
        check_eq("data", 32'(data), 32'(e.d));
        check_eq("write_cycle", 32'(cyc), 32'(e.c));
      end
    end
  end

  // Scoreboard for the no-gap instance
  always @(negedge clk) begin
    exp_t e;
    if (write6) begin
      if (q6.size() == 0) begin
        check_eq("unexpected_write6", 32'(write6), 32'd0);
      end else begin
        e = q6.pop_front();
        check_eq("data6", 32'(data6), 32'(e.d));
        check_eq("write_cycle6", 32'(cyc), 32'(e.c));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d, expected end before 20000", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         n, m, nw;
    logic [7:0] last;

    // Reset state
    tick(3);
    check_eq("rst_write", 32'(write), 32'd0);
    check_eq("rst_data", 32'(data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    tick(2);

    // Basic packet, busy window, speed change after capture, data hold
    speed = {14'h0ABC, 14'h1234};
    n = cyc;
    push_pkt(0, 16'h1234, 16'h0ABC, 14, n + 2, 2, 99, nw, last);
    pulse_done();
    speed = {14'h3FFF, 14'h2AAA};
    for (int c = n + 1; c <= n + 2 * nw + 1; c++) begin
      check_eq("busy_window", 32'(busy), 32'(c <= n + 2 * nw));
      tick(1);
    end
    check_eq("data_hold", 32'(data), 32'(last));
    check_eq("write_idle", 32'(write), 32'd0);
    check_eq("queue_empty_1", 32'(q0.size()), 32'd0);
    tick(2);

    // Back-pressure: full high through cycle n+4, low from n+5
    speed = {14'h0ABC, 14'h1234};
    full = 1'b1;
    n = cyc;
    push_pkt(0, 16'h1234, 16'h0ABC, 14, n + 6, 2, 99, nw, last);
    pulse_done();
    tick(4);
    check_eq("busy_stalled", 32'(busy), 32'd1);
    full = 1'b0;
    tick(2 * nw + 4);
    check_eq("queue_empty_3", 32'(q0.size()), 32'd0);
    check_eq("busy_after_3", 32'(busy), 32'd0);

    // Overrun: done re-pulsed at n+3 with new speed, then accepted when busy falls
    speed = {14'h0ABC, 14'h1234};
    n = cyc;
    push_pkt(0, 16'h1234, 16'h0ABC, 14, n + 2, 2, 99, nw, last);
    pulse_done();
    speed = {14'h1111, 14'h2222};
    tick(2);
    check_eq("overrun_pre", 32'(overrun), 32'd0);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    check_eq("overrun_pulse", 32'(overrun), 32'd1);
    tick(1);
    check_eq("overrun_clear", 32'(overrun), 32'd0);
    tick(2 * nw - 4);
    check_eq("busy_fall_cycle", 32'(busy), 32'd0);
    speed = {14'h3FFF, 14'h2A5C};
    m = cyc;
    push_pkt(0, 16'h2A5C, 16'h3FFF, 14, m + 2, 2, 99, nw, last);
    pulse_done();
    tick(2 * nw + 3);
    check_eq("queue_empty_4", 32'(q0.size()), 32'd0);

    // Reset mid-packet at n+5 aborts it; only two words may appear
    speed = {14'h0ABC, 14'h1234};
    n = cyc;
    push_pkt(0, 16'h1234, 16'h0ABC, 14, n + 2, 2, 2, nw, last);
    pulse_done();
    tick(4);
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_write", 32'(write), 32'd0);
    check_eq("async_rst_data", 32'(data), 32'd0);
    check_eq("async_rst_busy", 32'(busy), 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(12);
    check_eq("queue_empty_5", 32'(q0.size()), 32'd0);
    check_eq("busy_after_rst", 32'(busy), 32'd0);

    // No gap, 10-bit samples: back-to-back writes
    speed6 = {10'h001, 10'h3FF};
    n = cyc;
    push_pkt(6, 16'h03FF, 16'h0001, 10, n + 2, 1, 99, nw, last);
    done6 = 1'b1;
    tick(1);
    done6 = 1'b0;
    for (int c = n + 1; c <= n + nw + 2; c++) begin
      check_eq("busy6_window", 32'(busy6), 32'(c <= n + nw + 1));
      tick(1);
    end
    check_eq("data6_hold", 32'(data6), 32'(last));
    check_eq("queue_empty_6", 32'(q6.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
